// File: rtl/sram_ctrl.sv
// sram_ctrl: turns single-cycle CPU requests into timed 16-bit SRAM cycles.
// Optional write read-back check is built in when SRAM_WRITE_VERIFY_EN is defined.
module sram_ctrl #(
    parameter int ADDR_W  = 20,
    parameter int DATA_W  = 16,
    parameter int RD_WAIT = 2,
    parameter int WR_WAIT = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [1:0]        be,
    output logic              ready,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              verify_err,
    output logic [ADDR_W-1:0] ADDR,
    output logic              CE,
    output logic              UB,
    output logic              LB,
    output logic              OE,
    output logic              WE,
    output logic [DATA_W-1:0] Data_to_SRAM,
    input  logic [DATA_W-1:0] Data_from_SRAM,
    output logic              SRAM_DRIVE
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RD_ACC   = 3'd1;
    localparam logic [2:0] S_WR_SETUP = 3'd2;
    localparam logic [2:0] S_WR_PULSE = 3'd3;
    localparam logic [2:0] S_WR_HOLD  = 3'd4;
`ifdef SRAM_WRITE_VERIFY_EN
    localparam logic [2:0] S_VERIFY   = 3'd5;
`endif

    localparam int CNT_MAX = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_WAIT - 1);
    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_WAIT - 1);
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(CNT_MAX - 1);

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [CNT_W-1:0]  cnt_inc;
    logic [1:0]        be_q;
    logic [1:0]        be_nx;
    logic              accept;
    logic              rd_last;
    logic              wr_last;
    logic              done_nxt;
    logic              ce_nxt;
    logic              oe_nxt;
    logic              we_nxt;
    logic              ub_nxt;
    logic              lb_nxt;
    logic              drv_nxt;
    logic [DATA_W-1:0] rd_lanes;

    assign ready   = (state == S_IDLE);
    assign accept  = req && ready;
    assign be_nx   = accept ? be : be_q;
    assign rd_last = (cnt == RD_LAST);
    assign wr_last = (cnt == WR_LAST);
    assign cnt_inc = (cnt == CNT_TOP) ? cnt : cnt + 1'b1;

    // Disabled lanes read back as zero
    assign rd_lanes = {be_q[1] ? Data_from_SRAM[15:8] : 8'h00,
                       be_q[0] ? Data_from_SRAM[7:0]  : 8'h00};

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_inc;
        done_nxt  = 1'b0;
        unique case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                if (accept) begin
                    if (be == 2'b00) begin
                        done_nxt = 1'b1;
                    end else if (rw) begin
                        state_nxt = S_RD_ACC;
                    end else begin
                        state_nxt = S_WR_SETUP;
                    end
                end
            end
            S_RD_ACC: begin
                if (rd_last) begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            S_WR_SETUP: begin
                cnt_nxt   = '0;
                state_nxt = S_WR_PULSE;
            end
            S_WR_PULSE: begin
                if (wr_last) begin
                    state_nxt = S_WR_HOLD;
                end
            end
            S_WR_HOLD: begin
                cnt_nxt = '0;
`ifdef SRAM_WRITE_VERIFY_EN
                state_nxt = S_VERIFY;
`else
                state_nxt = S_IDLE;
                done_nxt  = 1'b1;
`endif
            end
`ifdef SRAM_WRITE_VERIFY_EN
            S_VERIFY: begin
                if (rd_last) begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                end
            end
`endif
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Strobes are registered from the state being entered
    always_comb begin
        ce_nxt  = 1'b1;
        oe_nxt  = 1'b1;
        we_nxt  = 1'b1;
        ub_nxt  = 1'b1;
        lb_nxt  = 1'b1;
        drv_nxt = 1'b0;
        unique case (state_nxt)
            S_RD_ACC: begin
                ce_nxt = 1'b0;
                oe_nxt = 1'b0;
                ub_nxt = ~be_nx[1];
                lb_nxt = ~be_nx[0];
            end
`ifdef SRAM_WRITE_VERIFY_EN
            S_VERIFY: begin
                ce_nxt = 1'b0;
                oe_nxt = 1'b0;
                ub_nxt = ~be_nx[1];
                lb_nxt = ~be_nx[0];
            end
`endif
            S_WR_SETUP, S_WR_HOLD: begin
                ce_nxt  = 1'b0;
                ub_nxt  = ~be_nx[1];
                lb_nxt  = ~be_nx[0];
                drv_nxt = 1'b1;
            end
            S_WR_PULSE: begin
                ce_nxt  = 1'b0;
                we_nxt  = 1'b0;
                ub_nxt  = ~be_nx[1];
                lb_nxt  = ~be_nx[0];
                drv_nxt = 1'b1;
            end
            default: begin
                ce_nxt = 1'b1;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            be_q         <= 2'b00;
            done         <= 1'b0;
            rdata        <= '0;
            ADDR         <= '0;
            Data_to_SRAM <= '0;
            CE           <= 1'b1;
            UB           <= 1'b1;
            LB           <= 1'b1;
            OE           <= 1'b1;
            WE           <= 1'b1;
            SRAM_DRIVE   <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            be_q       <= be_nx;
            done       <= done_nxt;
            CE         <= ce_nxt;
            UB         <= ub_nxt;
            LB         <= lb_nxt;
            OE         <= oe_nxt;
            WE         <= we_nxt;
            SRAM_DRIVE <= drv_nxt;
            if (accept) begin
                ADDR <= addr;
            end
            if (accept && !rw && (be != 2'b00)) begin
                Data_to_SRAM <= wdata;
            end
            if ((state == S_RD_ACC) && rd_last) begin
                rdata <= rd_lanes;
            end
        end
    end

`ifdef SRAM_WRITE_VERIFY_EN
    logic              verr_q;
    logic [DATA_W-1:0] wr_lanes;

    assign wr_lanes = {be_q[1] ? Data_to_SRAM[15:8] : 8'h00,
                       be_q[0] ? Data_to_SRAM[7:0]  : 8'h00};

    // Sticky until reset or the next accepted write
    always_ff @(posedge Clk) begin
        if (Reset) begin
            verr_q <= 1'b0;
        end else if (accept && !rw) begin
            verr_q <= 1'b0;
        end else if ((state == S_VERIFY) && rd_last && (rd_lanes != wr_lanes)) begin
            verr_q <= 1'b1;
        end
    end

    assign verify_err = verr_q;
`else
    assign verify_err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: directed and randomized checks of sram_ctrl against an SRAM
// model plus a word-level reference memory.
module tb_sram_ctrl;

    localparam int RD_WAIT = 2;
    localparam int WR_WAIT = 2;
`ifdef SRAM_WRITE_VERIFY_EN
    localparam int WR_LAT = WR_WAIT + 2 + RD_WAIT;
    localparam int WR_OE  = RD_WAIT;
`else
    localparam int WR_LAT = WR_WAIT + 2;
    localparam int WR_OE  = 0;
`endif

    logic        Clk;
    logic        Reset;
    logic        req;
    logic        rw;
    logic [19:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic        ready;
    logic        done;
    logic [15:0] rdata;
    logic        verify_err;
    logic [19:0] ADDR;
    logic        CE;
    logic        UB;
    logic        LB;
    logic        OE;
    logic        WE;
    logic [15:0] Data_to_SRAM;
    logic [15:0] Data_from_SRAM;
    logic        SRAM_DRIVE;

    sram_ctrl #(
        .ADDR_W (20),
        .DATA_W (16),
        .RD_WAIT(RD_WAIT),
        .WR_WAIT(WR_WAIT)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .req           (req),
        .rw            (rw),
        .addr          (addr),
        .wdata         (wdata),
        .be            (be),
        .ready         (ready),
        .done          (done),
        .rdata         (rdata),
        .verify_err    (verify_err),
        .ADDR          (ADDR),
        .CE            (CE),
        .UB            (UB),
        .LB            (LB),
        .OE            (OE),
        .WE            (WE),
        .Data_to_SRAM  (Data_to_SRAM),
        .Data_from_SRAM(Data_from_SRAM),
        .SRAM_DRIVE    (SRAM_DRIVE)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // SRAM device model; corrupt flips read-back bits
    logic [15:0] mem [0:2047];
    logic [15:0] corrupt;

    always @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < 2048; i++) mem[i] <= 16'h0000;
        end else if (!CE && !WE && SRAM_DRIVE) begin
            if (!UB) mem[ADDR[10:0]][15:8] <= Data_to_SRAM[15:8];
            if (!LB) mem[ADDR[10:0]][7:0]  <= Data_to_SRAM[7:0];
        end
    end

    assign Data_from_SRAM = (!CE && !OE) ? (mem[ADDR[10:0]] ^ corrupt) : 16'hDEAD;

    // Bus monitor: cumulative strobe counters and protocol violations
    int          c_we, c_oe, c_drv, c_any, c_we_ub, c_we_lb, c_oe_ub, c_oe_lb, viol;
    logic [19:0] p_addr;
    logic [15:0] p_data;
    logic        p_we;
    logic        rst_q;

    initial begin
        c_we = 0; c_oe = 0; c_drv = 0; c_any = 0;
        c_we_ub = 0; c_we_lb = 0; c_oe_ub = 0; c_oe_lb = 0; viol = 0;
    end

    always @(posedge Clk) rst_q <= Reset;

    always @(negedge Clk) begin
        if (!Reset && rst_q === 1'b0) begin
            if (!OE && SRAM_DRIVE) viol++;
            if ((ADDR !== p_addr || Data_to_SRAM !== p_data) && (!WE || !p_we)) viol++;
            if (!WE) c_we++;
            if (!OE) c_oe++;
            if (SRAM_DRIVE) c_drv++;
            if (!CE || !OE || !WE || !UB || !LB) c_any++;
            if (!WE && !UB) c_we_ub++;
            if (!WE && !LB) c_we_lb++;
            if (!OE && !UB) c_oe_ub++;
            if (!OE && !LB) c_oe_lb++;
        end
        p_addr = ADDR;
        p_data = Data_to_SRAM;
        p_we   = WE;
    end

    int s_we, s_oe, s_drv, s_any, s_we_ub, s_we_lb, s_oe_ub, s_oe_lb;

    task automatic snap();
        s_we = c_we; s_oe = c_oe; s_drv = c_drv; s_any = c_any;
        s_we_ub = c_we_ub; s_we_lb = c_we_lb; s_oe_ub = c_oe_ub; s_oe_lb = c_oe_lb;
    endtask

    int passed;
    int failed;
    int total;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one request from posedge+1; returns edges from accept to done
    task automatic run_op(input logic r, input logic [19:0] a, input logic [15:0] d,
                          input logic [1:0] b, output int lat);
        chk("ready_before_req", {31'd0, ready}, 32'd1);
        snap();
        req   = 1'b1;
        rw    = r;
        addr  = a;
        wdata = d;
        be    = b;
        @(posedge Clk);
        #1;
        req   = 1'b0;
        rw    = 1'($urandom);
        addr  = 20'($urandom);
        wdata = 16'($urandom);
        be    = 2'($urandom);
        lat   = 0;
        while (!done && lat < 40) begin
            @(posedge Clk);
            #1;
            lat++;
        end
    endtask

    logic [15:0] ref_mem [logic [19:0]];

    function automatic logic [15:0] lanes(input logic [15:0] v, input logic [1:0] b);
        return {b[1] ? v[15:8] : 8'h00, b[0] ? v[7:0] : 8'h00};
    endfunction

    function automatic logic [15:0] ref_rd(input logic [19:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 16'h0000;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "timeout");
    end

    int          lat;
    int          exp_lat;
    int          gap;
    logic        r_r;
    logic [19:0] r_a;
    logic [15:0] r_d;
    logic [1:0]  r_b;
    logic [15:0] cur;
    logic [15:0] exp_rdata;

    initial begin
        passed = 0; failed = 0; total = 0;
        Reset = 1'b1; req = 1'b0; rw = 1'b0; addr = '0; wdata = '0; be = 2'b00;
        corrupt = 16'h0000;
        repeat (3) @(posedge Clk);
        #1;
        Reset = 1'b0;

        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_strobes", {27'd0, CE, UB, LB, OE, WE}, 32'h1F);
        chk("rst_drive", {31'd0, SRAM_DRIVE}, 32'd0);
        chk("rst_rdata", {16'd0, rdata}, 32'd0);
        chk("rst_addr", {12'd0, ADDR}, 32'd0);
        chk("rst_wdata", {16'd0, Data_to_SRAM}, 32'd0);
        chk("rst_verr", {31'd0, verify_err}, 32'd0);

        run_op(1'b0, 20'h12345, 16'hBEEF, 2'b11, lat);
        chk("wr_lat", lat, WR_LAT);
        chk("wr_we_cycles", c_we - s_we, WR_WAIT);
        chk("wr_oe_cycles", c_oe - s_oe, WR_OE);
        chk("wr_drive_cycles", c_drv - s_drv, WR_WAIT + 2);
        chk("wr_addr", {12'd0, ADDR}, 32'h12345);
        chk("wr_mem", {16'd0, mem[11'h345]}, 32'hBEEF);

        run_op(1'b1, 20'h12345, 16'h0000, 2'b11, lat);
        chk("rd_lat", lat, RD_WAIT);
        chk("rd_data", {16'd0, rdata}, 32'hBEEF);
        chk("rd_oe_cycles", c_oe - s_oe, RD_WAIT);
        chk("rd_we_cycles", c_we - s_we, 0);
        chk("rd_drive_cycles", c_drv - s_drv, 0);

        run_op(1'b0, 20'h12346, 16'hA55A, 2'b11, lat);
        run_op(1'b1, 20'h12346, 16'h0000, 2'b01, lat);
        chk("lane_rd_data", {16'd0, rdata}, 32'h005A);
        chk("lane_rd_ub", c_oe_ub - s_oe_ub, 0);
        chk("lane_rd_lb", c_oe_lb - s_oe_lb, RD_WAIT);

        run_op(1'b0, 20'h12347, 16'h1111, 2'b11, lat);
        run_op(1'b0, 20'h12347, 16'h7788, 2'b10, lat);
        chk("lane_wr_ub", c_we_ub - s_we_ub, WR_WAIT);
        chk("lane_wr_lb", c_we_lb - s_we_lb, 0);
        run_op(1'b1, 20'h12347, 16'h0000, 2'b11, lat);
        chk("lane_wr_merge", {16'd0, rdata}, 32'h7711);

        run_op(1'b1, 20'h12346, 16'h0000, 2'b00, lat);
        chk("noop_lat", lat, 0);
        chk("noop_strobes", c_any - s_any, 0);
        chk("noop_rdata", {16'd0, rdata}, 32'h7711);
        chk("noop_ready", {31'd0, ready}, 32'd1);

        // Back-to-back reads with req held high throughout
        run_op(1'b0, 20'h12350, 16'h1357, 2'b11, lat);
        run_op(1'b0, 20'h12351, 16'h2468, 2'b11, lat);
        req = 1'b1; rw = 1'b1; be = 2'b11; addr = 20'h12350;
        @(posedge Clk);
        #1;
        addr = 20'h12351;
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge Clk);
            #1;
            lat++;
        end
        chk("b2b_lat1", lat, RD_WAIT);
        chk("b2b_rd1", {16'd0, rdata}, 32'h1357);
        @(posedge Clk);
        #1;
        chk("b2b_no_gap", {31'd0, ready}, 32'd0);
        req = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge Clk);
            #1;
            lat++;
        end
        chk("b2b_lat2", lat, RD_WAIT);
        chk("b2b_rd2", {16'd0, rdata}, 32'h2468);

        // Reset in the middle of the write pulse
        req = 1'b1; rw = 1'b0; addr = 20'h12360; wdata = 16'hCAFE; be = 2'b11;
        @(posedge Clk);
        #1;
        req = 1'b0;
        @(posedge Clk);
        #1;
        chk("mid_we_low", {31'd0, WE}, 32'd0);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        chk("mid_rst_we_ce", {30'd0, WE, CE}, 32'd3);
        chk("mid_rst_drive", {31'd0, SRAM_DRIVE}, 32'd0);
        chk("mid_rst_ready", {31'd0, ready}, 32'd1);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        chk("mid_rst_rdata", {16'd0, rdata}, 32'd0);

        // Random traffic against the reference memory
        exp_rdata = 16'h0000;
        for (int i = 0; i < 200; i++) begin
            r_r = 1'($urandom);
            r_a = 20'h80400 + 20'($urandom_range(0, 1023));
            r_d = 16'($urandom);
            r_b = 2'($urandom);
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                @(posedge Clk);
                #1;
            end
            run_op(r_r, r_a, r_d, r_b, lat);
            if (r_b == 2'b00) exp_lat = 0;
            else if (r_r) exp_lat = RD_WAIT;
            else exp_lat = WR_LAT;
            chk("rand_lat", lat, exp_lat);
            if (r_b != 2'b00) begin
                if (r_r) begin
                    exp_rdata = lanes(ref_rd(r_a), r_b);
                end else begin
                    cur = ref_rd(r_a);
                    if (r_b[1]) cur[15:8] = r_d[15:8];
                    if (r_b[0]) cur[7:0] = r_d[7:0];
                    ref_mem[r_a] = cur;
                end
            end
            chk("rand_rdata", {16'd0, rdata}, {16'd0, exp_rdata});
        end
        chk("bus_safety", viol, 0);
        chk("rand_verr", {31'd0, verify_err}, 32'd0);

`ifdef SRAM_WRITE_VERIFY_EN
        corrupt = 16'hFF00;
        run_op(1'b0, 20'h12370, 16'h1234, 2'b11, lat);
        chk("vfy_lat", lat, WR_LAT);
        chk("vfy_err_set", {31'd0, verify_err}, 32'd1);
        chk("vfy_rdata", {16'd0, rdata}, {16'd0, exp_rdata});
        corrupt = 16'h0000;
        run_op(1'b0, 20'h12371, 16'h5678, 2'b11, lat);
        chk("vfy_err_clr", {31'd0, verify_err}, 32'd0);
        chk("vfy_bus_safety", viol, 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
